// File: rtl/param_register_bank_if.sv
// Bus-side request/response signals of the parameterised register bank.
// The master issues one-cycle read/write requests; the slave returns registered pulses.
interface param_register_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    readEnable;
    logic                    writeEnable;
    logic [DATA_WIDTH-1:0]   writeData;
    logic [DATA_WIDTH/8-1:0] byteEnable;
    logic                    writeAdmin;
    logic [DATA_WIDTH-1:0]   readData;
    logic                    readValid;
    logic                    writeAck;
    logic                    accessError;

    modport master (
        output address, readEnable, writeEnable, writeData, byteEnable, writeAdmin,
        input  readData, readValid, writeAck, accessError
    );

    modport slave (
        input  address, readEnable, writeEnable, writeData, byteEnable, writeAdmin,
        output readData, readValid, writeAck, accessError
    );
endinterface

// File: rtl/param_register_bank.sv
// Control/status register bank with per-register access type (RW, RO, W1C, WO-pulse),
// byte-lane writes, hardware OR-set inputs and per-register software write strobes.
module param_register_bank #(
    parameter int                               DATA_WIDTH   = 32,
    parameter int                               ADDR_WIDTH   = 4,
    parameter int                               NUM_REGS     = 16,
    parameter logic [NUM_REGS-1:0]              RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]              W1C_MASK     = '0,
    parameter logic [NUM_REGS-1:0]              WO_MASK      = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
    input  logic                             clk,
    input  logic                             rstn,
    param_register_bank_if.slave             bus,
    input  logic [NUM_REGS-1:0]              hwSetValid,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   hwSetData,
    output logic [NUM_REGS-1:0]              writeStrobe,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   regsOut
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    // Overlapping masks resolve as W1C over WO over RO.
    localparam logic [NUM_REGS-1:0] IS_W1C = W1C_MASK;
    localparam logic [NUM_REGS-1:0] IS_WO  = WO_MASK & ~W1C_MASK;
    localparam logic [NUM_REGS-1:0] IS_RO  = RO_MASK & ~W1C_MASK & ~WO_MASK;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  write_ack_q, write_ack_d;
    logic                  access_error_q, access_error_d;
    logic [NUM_REGS-1:0]   write_strobe_q, write_strobe_d;

    logic                  rd_req;
    logic                  wr_req;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rd_req         = bus.readEnable;
        wr_req         = bus.writeEnable & ~bus.readEnable;
        addr_ok        = int'(bus.address) < NUM_REGS;
        lane_mask      = '0;
        for (int b = 0; b < NUM_LANES; b++) begin
            lane_mask[b*8 +: 8] = {8{bus.byteEnable[b]}};
        end
        wr_data        = bus.writeData & lane_mask;

        read_data_d    = rd_req ? '0 : read_data_q;
        read_valid_d   = rd_req;
        write_ack_d    = wr_req;
        access_error_d = (rd_req | wr_req) & ~addr_ok;
        write_strobe_d = '0;

        for (int i = 0; i < NUM_REGS; i++) begin
            // WO registers fall back to their reset slice unless rewritten this cycle.
            regs_d[i] = IS_WO[i] ? RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];

            if (rd_req && int'(bus.address) == i && !IS_WO[i]) begin
                read_data_d = regs_q[i];
            end

            if (wr_req && int'(bus.address) == i) begin
                if (IS_RO[i] && !bus.writeAdmin) begin
                    access_error_d = 1'b1;
                end else begin
                    write_strobe_d[i] = 1'b1;
                    if (IS_W1C[i] && !bus.writeAdmin) begin
                        regs_d[i] = regs_q[i] & ~wr_data;
                    end else begin
                        regs_d[i] = (regs_d[i] & ~lane_mask) | wr_data;
                    end
                end
            end

            // Hardware OR lands after the software update, so a same-cycle W1C cannot hide it.
            if (hwSetValid[i] && !IS_WO[i]) begin
                regs_d[i] = regs_d[i] | hwSetData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the register array is reset element by element because each entry has a
            // distinct architectural reset value that software and datapath rely on.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
            end
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            write_ack_q    <= 1'b0;
            access_error_q <= 1'b0;
            write_strobe_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge state.
            regs_q         <= regs_d;
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            write_ack_q    <= write_ack_d;
            access_error_q <= access_error_d;
            write_strobe_q <= write_strobe_d;
        end
    end

    assign bus.readData    = read_data_q;
    assign bus.readValid   = read_valid_q;
    assign bus.writeAck    = write_ack_q;
    assign bus.accessError = access_error_q;
    assign writeStrobe     = write_strobe_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regsOut[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench for param_register_bank: expected bus responses go into a scoreboard
// queue when a request is driven and are popped and compared one cycle later.
module tb_param_register_bank;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 12;
    localparam logic [NR-1:0]    RO  = 12'h0C8;  // regs 3, 6, 7
    localparam logic [NR-1:0]    W1C = 12'h050;  // regs 4, 6
    localparam logic [NR-1:0]    WO  = 12'h0E0;  // regs 5, 6, 7
    localparam logic [NR*DW-1:0] RV  = (384'hA5 << 64) | (384'hFF << 192) | (384'h77 << 224);

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    hw_set_valid;
    logic [NR*DW-1:0] hw_set_data;
    logic [NR-1:0]    write_strobe;
    logic [NR*DW-1:0] regs_out;

    always #5 clk = ~clk;

    param_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_register_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .RO_MASK(RO), .W1C_MASK(W1C), .WO_MASK(WO), .RESET_VALUES(RV)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .hwSetValid (hw_set_valid),
        .hwSetData  (hw_set_data),
        .writeStrobe(write_strobe),
        .regsOut    (regs_out)
    );

    typedef struct {
        string         tag;
        logic          rv;
        logic [DW-1:0] rd;
        logic          ack;
        logic          err;
        logic [NR-1:0] strobe;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] last_rd;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic push(input string tag, input logic rv, input logic [DW-1:0] rd,
                        input logic ack, input logic err, input logic [NR-1:0] strobe);
        exp_t e;
        if (rv) last_rd = rd;
        e.tag = tag; e.rv = rv; e.rd = last_rd; e.ack = ack; e.err = err; e.strobe = strobe;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.readEnable  = 1'b0;
        bus.writeEnable = 1'b0;
        bus.writeAdmin  = 1'b0;
        bus.address     = '0;
        bus.writeData   = '0;
        bus.byteEnable  = '0;
        hw_set_valid    = '0;
        hw_set_data     = '0;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        clear_inputs();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: observed no entry required one entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_readValid"},   64'(bus.readValid),   64'(e.rv));
            check({e.tag, "_readData"},    64'(bus.readData),    64'(e.rd));
            check({e.tag, "_writeAck"},    64'(bus.writeAck),    64'(e.ack));
            check({e.tag, "_accessError"}, 64'(bus.accessError), 64'(e.err));
            check({e.tag, "_writeStrobe"}, 64'(write_strobe),    64'(e.strobe));
        end
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] be, input logic adm, input logic exp_err,
                      input logic [NR-1:0] exp_strobe);
        bus.address = a; bus.writeData = d; bus.byteEnable = be; bus.writeAdmin = adm;
        bus.writeEnable = 1'b1;
        push(tag, 1'b0, '0, 1'b1, exp_err, exp_strobe);
        tick();
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                      input logic exp_err);
        bus.address = a; bus.readEnable = 1'b1;
        push(tag, 1'b1, exp_d, 1'b0, exp_err, '0);
        tick();
    endtask

    task automatic idle(input string tag);
        push(tag, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
    endtask

    initial begin
        clear_inputs();
        last_rd = '0;
        rstn = 1'b0;
        #12;
        check("rst_slice2",      64'(slice(2)), 64'h0000_00A5);
        check("rst_slice6",      64'(slice(6)), 64'h0000_00FF);
        check("rst_slice7",      64'(slice(7)), 64'h0000_0077);
        check("rst_slice1",      64'(slice(1)), 64'h0);
        check("rst_readValid",   64'(bus.readValid),   64'h0);
        check("rst_readData",    64'(bus.readData),    64'h0);
        check("rst_writeAck",    64'(bus.writeAck),    64'h0);
        check("rst_accessError", 64'(bus.accessError), 64'h0);
        check("rst_writeStrobe", 64'(write_strobe),    64'h0);
        rstn = 1'b1;

        idle("post_reset");
        rd("rd_reset_r2", 4'd2, 32'h0000_00A5, 1'b0);
        idle("rd_hold");

        wr("wr_rw_lanes", 4'd1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0, 12'h002);
        check("rw_lanes_slice1", 64'(slice(1)), 64'h0000_BEEF);
        idle("rw_strobe_drop");
        rd("rd_rw_r1", 4'd1, 32'h0000_BEEF, 1'b0);

        wr("wr_ro_noadmin", 4'd3, 32'h55, 4'hF, 1'b0, 1'b1, 12'h000);
        check("ro_noadmin_slice3", 64'(slice(3)), 64'h0);
        wr("wr_ro_admin", 4'd3, 32'h55, 4'hF, 1'b1, 1'b0, 12'h008);
        check("ro_admin_slice3", 64'(slice(3)), 64'h55);

        hw_set_valid = 12'h010;
        hw_set_data  = 384'h0F << 128;
        idle("hw_set_r4");
        check("hw_set_slice4", 64'(slice(4)), 64'h0F);
        hw_set_valid = 12'h010;
        hw_set_data  = 384'h01 << 128;
        wr("wr_w1c_hw", 4'd4, 32'h03, 4'hF, 1'b0, 1'b0, 12'h010);
        check("w1c_hw_slice4", 64'(slice(4)), 64'h0D);
        wr("wr_w1c_clear", 4'd4, 32'h0C, 4'hF, 1'b0, 1'b0, 12'h010);
        check("w1c_clear_slice4", 64'(slice(4)), 64'h01);

        wr("wr_wo_r5", 4'd5, 32'h1, 4'hF, 1'b0, 1'b0, 12'h020);
        check("wo_pulse_slice5", 64'(slice(5)), 64'h1);
        idle("wo_selfclear");
        check("wo_clear_slice5", 64'(slice(5)), 64'h0);
        rd("rd_wo_r5", 4'd5, 32'h0, 1'b0);
        hw_set_valid = 12'h020;
        hw_set_data  = 384'hFF << 160;
        idle("wo_hw_ignored");
        check("wo_hw_slice5", 64'(slice(5)), 64'h0);

        wr("wr_wo_over_ro", 4'd7, 32'h12, 4'hF, 1'b0, 1'b0, 12'h080);
        check("wo_over_ro_slice7", 64'(slice(7)), 64'h12);
        idle("wo_r7_restore");
        check("wo_restore_slice7", 64'(slice(7)), 64'h77);
        wr("wr_w1c_over_all", 4'd6, 32'h0F, 4'hF, 1'b0, 1'b0, 12'h040);
        check("w1c_over_slice6", 64'(slice(6)), 64'hF0);
        idle("w1c_r6_persist");
        check("w1c_persist_slice6", 64'(slice(6)), 64'hF0);

        bus.address = 4'd1; bus.writeData = 32'h0; bus.byteEnable = 4'hF;
        bus.readEnable = 1'b1; bus.writeEnable = 1'b1;
        push("rd_wr_collide", 1'b1, 32'h0000_BEEF, 1'b0, 1'b0, '0);
        tick();
        check("collide_slice1", 64'(slice(1)), 64'h0000_BEEF);

        rd("rd_bad_addr", 4'd15, 32'h0, 1'b1);
        wr("wr_bad_addr", 4'd12, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 12'h000);

        wr("wr_b2b_a", 4'd0, 32'h11, 4'hF, 1'b0, 1'b0, 12'h001);
        check("b2b_a_slice0", 64'(slice(0)), 64'h11);
        wr("wr_b2b_b", 4'd0, 32'h22, 4'hF, 1'b0, 1'b0, 12'h001);
        check("b2b_b_slice0", 64'(slice(0)), 64'h22);

        wr("wr_pre_reset", 4'd1, 32'h1234, 4'hF, 1'b0, 1'b0, 12'h002);
        check("pre_reset_slice1", 64'(slice(1)), 64'h1234);
        rstn = 1'b0;
        #1;
        check("midrst_writeAck",    64'(bus.writeAck),  64'h0);
        check("midrst_writeStrobe", 64'(write_strobe),  64'h0);
        check("midrst_readData",    64'(bus.readData),  64'h0);
        check("midrst_slice1",      64'(slice(1)),      64'h0);
        check("midrst_slice0",      64'(slice(0)),      64'h0);
        @(negedge clk);
        rstn = 1'b1;
        last_rd = '0;
        idle("post_midrst");
        rd("rd_after_midrst", 4'd2, 32'h0000_00A5, 1'b0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_register_bank.md
# param_register_bank

Parametrised control/status register bank for the amorce design: a generalised successor of the fixed 16×32 register file, with configurable register count and width, per-register access type (RW, RO, W1C, WO-pulse), byte-lane writes, hardware-side status setting and per-register write strobes. It sits between the SPI/bus slave front end and the datapath blocks. It replaces hand-coded strobes, such as the sync-clear and channel-update strobes, with a generic per-register strobe vector.

## Interface
- DATA_WIDTH, 32, register width in bits; multiple of 8
- ADDR_WIDTH, 4, address bus width
- NUM_REGS, 16, implemented registers; must be ≤ 2**ADDR_WIDTH
- RO_MASK, '0, NUM_REGS bits; 1 = read-only unless writeAdmin
- W1C_MASK, '0, NUM_REGS bits; 1 = write-one-to-clear status register
- WO_MASK, '0, NUM_REGS bits; 1 = write-only pulse register (self-clears)
- RESET_VALUES, '0, NUM_REGS*DATA_WIDTH bits; register i at slice [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- address  in  ADDR_WIDTH  register index
- readEnable  in  1  read request, one cycle
- writeEnable  in  1  write request, one cycle
- writeData  in  DATA_WIDTH  write value
- byteEnable  in  DATA_WIDTH/8  byte-lane mask for writes
- writeAdmin  in  1  privileged write; bypasses RO protection
- hwSetValid  in  NUM_REGS  hardware set request per register
- hwSetData  in  NUM_REGS*DATA_WIDTH  bits ORed into the register when hwSetValid[i] is 1
- readData  out  DATA_WIDTH  registered read value
- readValid  out  1  one-cycle pulse; readData is valid
- writeAck  out  1  one-cycle pulse per accepted write request
- accessError  out  1  one-cycle pulse: bad address or RO violation
- writeStrobe  out  NUM_REGS  one-hot pulse; register i was modified by software
- regsOut  out  NUM_REGS*DATA_WIDTH  current value of all registers

## Operation
- Reset (rstn=0, asynchronous): registers load RESET_VALUES. readData, readValid, writeAck, accessError and writeStrobe go to 0.
- Request priority: readEnable beats writeEnable. A write presented together with a read is dropped; no ack.
- Read: address < NUM_REGS loads the register value into readData. WO registers read as 0. Address ≥ NUM_REGS returns 0 and pulses accessError. readData holds its value until the next read.
- Write, address < NUM_REGS, per type (only lanes with byteEnable=1 are affected):
  - RW: lane replaced with writeData.
  - RO with writeAdmin=0: no change, accessError pulses.
  - RO with writeAdmin=1: written like RW.
  - W1C: bits set in writeData are cleared. With writeAdmin=1, the lane is overwritten like RW.
  - WO: lane written; the register returns to its RESET_VALUES slice on the next edge, unless written again in that cycle.
- Write, address ≥ NUM_REGS: ignored, accessError pulses.
- writeAck pulses for every write request, including ignored ones, so the bus never stalls.
- writeStrobe[i] pulses only when register i was actually written.
- Hardware set: when hwSetValid[i]=1, register i ← register i | hwSetData slice. Applies to every type except WO; WO ignores hwSetValid.
- Same-cycle software write and hardware set to one register: the software write applies first, then the hardware OR. A status bit set by hardware is never lost to a W1C clear in the same cycle.
- Masks overlap: W1C has precedence over WO, WO over RO.

## Timing
- Read latency is 1 cycle. readEnable sampled at edge N gives readData and readValid=1 after edge N; readValid is 1 for one cycle.
- Write latency is 1 cycle. Register update, writeAck, writeStrobe and accessError all appear after the sampling edge. regsOut reflects the new value in the same cycle writeAck is high.
- Back-to-back requests on consecutive cycles are each serviced. writeAck stays high continuously over consecutive writes.
- A WO register is non-reset on regsOut for exactly one cycle per write.
- Reset asserted mid-operation aborts any pulse. Outputs are at reset values while rstn=0 and for the first cycle after release.
- No combinational path from inputs to outputs.

## Test plan
- Reset with RESET_VALUES slice 2 = 0x0000_00A5 -> regsOut slice 2 = 0xA5; all pulses 0; a read of address 2 returns 0xA5 with readValid one cycle later.
- Write 0xDEADBEEF with byteEnable=4'b0011 to RW register 1 (reset 0) -> readback 0x0000BEEF, writeAck and writeStrobe[1] pulse one cycle.
- RO register 3 (RO_MASK[3]=1): write 0x55 with writeAdmin=0 -> value unchanged, accessError and writeAck pulse. The same write with writeAdmin=1 -> value 0x55, writeStrobe[3] pulses.
- W1C register 4 holding 0x0F: write 0x03 with hwSetValid[4]=1 and hwSetData=0x01 in the same cycle -> value 0x0D.
- WO register 5: write 0x1 -> regsOut slice 5 = 0x1 for exactly one cycle, then 0. A read of register 5 returns 0.
- readEnable and writeEnable together to address 1 -> read serviced, register unchanged, no writeAck. A read of address 15 with NUM_REGS=12 -> readData=0, accessError pulses.
